// File: rtl/ct_had_xtrig_pkg.sv
// Shared constants for the HAD cross-trigger unit: register offsets,
// APB FSM state encoding and APB error causes.
package ct_had_xtrig_pkg;

  localparam logic [7:0] OFF_CTRL        = 8'h00;
  localparam logic [7:0] OFF_HALT_GRP    = 8'h04;
  localparam logic [7:0] OFF_RESUME_GRP  = 8'h08;
  localparam logic [7:0] OFF_HALT_PEND   = 8'h0C;
  localparam logic [7:0] OFF_RESUME_PEND = 8'h10;
  localparam logic [7:0] OFF_SW_HALT     = 8'h14;
  localparam logic [7:0] OFF_SW_RESUME   = 8'h18;
  localparam logic [7:0] OFF_CLR         = 8'h1C;

  typedef enum logic [1:0] {
    APB_IDLE = 2'd0,
    APB_WAIT = 2'd1,
    APB_RESP = 2'd2
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_RO_WRITE = 2'd3
  } apb_err_e;

endpackage

// File: rtl/ct_had_xtrig_apb.sv
// APB slave with one wait state: address decode, register file and
// write-1 pulses toward the cross-trigger pending logic.
module ct_had_xtrig_apb
  import ct_had_xtrig_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int PADDR_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [PADDR_W-1:0]   paddr,
  input  logic [31:0]          pwdata,
  input  logic [NUM_CORES-1:0] halt_pend,
  input  logic [NUM_CORES-1:0] resume_pend,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 perr,
  output logic                 xtrig_en,
  output logic [NUM_CORES-1:0] halt_grp,
  output logic [NUM_CORES-1:0] resume_grp,
  output logic [NUM_CORES-1:0] sw_halt,
  output logic [NUM_CORES-1:0] sw_resume,
  output logic [NUM_CORES-1:0] clr
);

  apb_state_e             state_q, state_d;
  apb_err_e               err_q, err_d, dec_err;
  logic [PADDR_W-1:0]     addr_q, addr_d;
  logic [NUM_CORES-1:0]   wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [31:0]            rdata_q, rdata_d, dec_rdata;
  logic                   en_q, en_d;
  logic [NUM_CORES-1:0]   hgrp_q, hgrp_d;
  logic [NUM_CORES-1:0]   rgrp_q, rgrp_d;
  logic                   unused_pwdata;

  assign unused_pwdata = ^pwdata[31:NUM_CORES];

  always_comb begin
    dec_err   = ERR_NONE;
    dec_rdata = '0;
    if (paddr[1:0] != 2'b00) begin
      dec_err = ERR_MISALIGN;
    end else begin
      case (paddr)
        PADDR_W'(OFF_CTRL):       dec_rdata = {31'd0, en_q};
        PADDR_W'(OFF_HALT_GRP):   dec_rdata = 32'(hgrp_q);
        PADDR_W'(OFF_RESUME_GRP): dec_rdata = 32'(rgrp_q);
        PADDR_W'(OFF_HALT_PEND): begin
          dec_rdata = 32'(halt_pend);
          if (pwrite) dec_err = ERR_RO_WRITE;
        end
        PADDR_W'(OFF_RESUME_PEND): begin
          dec_rdata = 32'(resume_pend);
          if (pwrite) dec_err = ERR_RO_WRITE;
        end
        PADDR_W'(OFF_SW_HALT), PADDR_W'(OFF_SW_RESUME), PADDR_W'(OFF_CLR):
          dec_rdata = '0;
        default: dec_err = ERR_UNMAPPED;
      endcase
    end
  end

  // Read data and error are captured at accept; the write commits in RESP
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    en_d      = en_q;
    hgrp_d    = hgrp_q;
    rgrp_d    = rgrp_q;
    sw_halt   = '0;
    sw_resume = '0;
    clr       = '0;
    pready    = 1'b0;
    perr      = 1'b0;
    prdata    = '0;
    case (state_q)
      APB_IDLE: begin
        if (psel && penable) begin
          state_d = APB_WAIT;
          err_d   = dec_err;
          addr_d  = paddr;
          wdata_d = pwdata[NUM_CORES-1:0];
          write_d = pwrite;
          rdata_d = dec_rdata;
        end
      end
      APB_WAIT: state_d = APB_RESP;
      APB_RESP: begin
        state_d = APB_IDLE;
        pready  = 1'b1;
        perr    = (err_q != ERR_NONE);
        prdata  = rdata_q;
        if (write_q && (err_q == ERR_NONE)) begin
          case (addr_q)
            PADDR_W'(OFF_CTRL):       en_d      = wdata_q[0];
            PADDR_W'(OFF_HALT_GRP):   hgrp_d    = wdata_q;
            PADDR_W'(OFF_RESUME_GRP): rgrp_d    = wdata_q;
            PADDR_W'(OFF_SW_HALT):    sw_halt   = wdata_q;
            PADDR_W'(OFF_SW_RESUME):  sw_resume = wdata_q;
            PADDR_W'(OFF_CLR):        clr       = wdata_q;
            default: ;
          endcase
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= APB_IDLE;
      err_q   <= ERR_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      hgrp_q  <= '0;
      rgrp_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      hgrp_q  <= hgrp_d;
      rgrp_q  <= rgrp_d;
    end
  end

  assign xtrig_en   = en_q;
  assign halt_grp   = hgrp_q;
  assign resume_grp = rgrp_q;

endmodule

// File: rtl/ct_had_xtrig.sv
// HAD cross-trigger unit: broadcasts held halt/resume requests across
// programmable core groups until each target core acknowledges.
module ct_had_xtrig
  import ct_had_xtrig_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int PADDR_W   = 8
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic [NUM_CORES-1:0] core_enter_dbg_req_o,
  input  logic [NUM_CORES-1:0] core_exit_dbg_req_o,
  input  logic [NUM_CORES-1:0] core_dbg_ack_pc,
  output logic [NUM_CORES-1:0] core_enter_dbg_req_i,
  output logic [NUM_CORES-1:0] core_exit_dbg_req_i,
  input  logic                 psel_had,
  input  logic                 penable_had,
  input  logic                 pwrite_had,
  input  logic [PADDR_W-1:0]   paddr_had,
  input  logic [31:0]          pwdata_had,
  output logic [31:0]          prdata_had,
  output logic                 pready_had,
  output logic                 perr_had
);

  logic                 xtrig_en;
  logic [NUM_CORES-1:0] halt_grp, resume_grp, sw_halt, sw_resume, clr;
  logic [NUM_CORES-1:0] enter_q, enter_qq, exit_q, exit_qq;
  logic [NUM_CORES-1:0] halt_pend_q, halt_pend_d, resume_pend_q, resume_pend_d;
  logic [NUM_CORES-1:0] halt_src, resume_src, halt_set, resume_set;

  ct_had_xtrig_apb #(
    .NUM_CORES (NUM_CORES),
    .PADDR_W   (PADDR_W)
  ) u_apb (
    .clk         (forever_cpuclk),
    .rst         (cpurst),
    .psel        (psel_had),
    .penable     (penable_had),
    .pwrite      (pwrite_had),
    .paddr       (paddr_had),
    .pwdata      (pwdata_had),
    .halt_pend   (halt_pend_q),
    .resume_pend (resume_pend_q),
    .prdata      (prdata_had),
    .pready      (pready_had),
    .perr        (perr_had),
    .xtrig_en    (xtrig_en),
    .halt_grp    (halt_grp),
    .resume_grp  (resume_grp),
    .sw_halt     (sw_halt),
    .sw_resume   (sw_resume),
    .clr         (clr)
  );

  always_comb begin
    halt_src      = xtrig_en ? (enter_q & ~enter_qq & halt_grp)  : '0;
    resume_src    = xtrig_en ? (exit_q  & ~exit_qq  & resume_grp) : '0;
    halt_set      = sw_halt;
    resume_set    = sw_resume;
    halt_pend_d   = halt_pend_q;
    resume_pend_d = resume_pend_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      // A core never triggers itself; only other group members count
      if (halt_grp[k] && !core_dbg_ack_pc[k] &&
          |(halt_src & ~(NUM_CORES'(1) << k)))
        halt_set[k] = 1'b1;
      if (resume_grp[k] && core_dbg_ack_pc[k] &&
          |(resume_src & ~(NUM_CORES'(1) << k)))
        resume_set[k] = 1'b1;
      // Ack level clears one pending and gates the set of the other
      if (clr[k]) begin
        halt_pend_d[k]   = 1'b0;
        resume_pend_d[k] = 1'b0;
      end else if (core_dbg_ack_pc[k]) begin
        halt_pend_d[k]   = 1'b0;
        resume_pend_d[k] = resume_pend_q[k] | resume_set[k];
      end else begin
        resume_pend_d[k] = 1'b0;
        halt_pend_d[k]   = halt_pend_q[k] | halt_set[k];
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      enter_q       <= '0;
      enter_qq      <= '0;
      exit_q        <= '0;
      exit_qq       <= '0;
      halt_pend_q   <= '0;
      resume_pend_q <= '0;
    end else begin
      enter_q       <= core_enter_dbg_req_o;
      enter_qq      <= enter_q;
      exit_q        <= core_exit_dbg_req_o;
      exit_qq       <= exit_q;
      halt_pend_q   <= halt_pend_d;
      resume_pend_q <= resume_pend_d;
    end
  end

  assign core_enter_dbg_req_i = halt_pend_q;
  assign core_exit_dbg_req_i  = resume_pend_q;

endmodule

// File: tb/tb_ct_had_xtrig.sv
// Scoreboard bench for ct_had_xtrig: a rule-level reference model predicts
// request outputs every cycle and the response of every APB transfer.
module tb_ct_had_xtrig;

  localparam int NC   = 4;
  localparam int MASK = (1 << NC) - 1;

  logic          clk = 1'b0;
  logic          cpurst = 1'b1;
  logic [NC-1:0] enter_o = '0, exit_o = '0, ack = '0;
  logic [NC-1:0] enter_i, exit_i;
  logic          psel_had = 1'b0, penable_had = 1'b0, pwrite_had = 1'b0;
  logic [7:0]    paddr_had = '0;
  logic [31:0]   pwdata_had = '0;
  logic [31:0]   prdata_had;
  logic          pready_had, perr_had;

  always #5 clk = ~clk;

  ct_had_xtrig #(.NUM_CORES(NC), .PADDR_W(8)) dut (
    .forever_cpuclk       (clk),
    .cpurst               (cpurst),
    .core_enter_dbg_req_o (enter_o),
    .core_exit_dbg_req_o  (exit_o),
    .core_dbg_ack_pc      (ack),
    .core_enter_dbg_req_i (enter_i),
    .core_exit_dbg_req_i  (exit_i),
    .psel_had             (psel_had),
    .penable_had          (penable_had),
    .pwrite_had           (pwrite_had),
    .paddr_had            (paddr_had),
    .pwdata_had           (pwdata_had),
    .prdata_had           (prdata_had),
    .pready_had           (pready_had),
    .perr_had             (perr_had)
  );

  typedef struct { int rd; bit err; bit is_rd; int cyc; } apb_exp_t;
  typedef struct { int en; int ex; } out_exp_t;

  apb_exp_t apb_q[$];
  out_exp_t out_q[$];
  int total = 0, bad = 0, cyc = 0;

  bit acc_pending = 0, acc_w = 0;
  int acc_addr = 0, acc_data = 0;

  int m_en = 0, m_hgrp = 0, m_rgrp = 0;
  bit m_hp[NC], m_rp[NC], m_h1e[NC], m_h2e[NC], m_h1x[NC], m_h2x[NC];
  int commit_cyc = -1, c_addr = 0, c_data = 0;
  bit c_w = 0, c_err = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pend_word(input bit halt);
    int v = 0;
    for (int k = 0; k < NC; k++)
      if (halt ? m_hp[k] : m_rp[k]) v |= (1 << k);
    return v;
  endfunction

  function automatic void decode(input int a, input bit w, output bit err, output int rd);
    err = 0;
    rd  = 0;
    if ((a % 4) != 0 || a >= 32) err = 1;
    else case (a)
      0:  rd = m_en;
      4:  rd = m_hgrp;
      8:  rd = m_rgrp;
      12: begin rd = pend_word(1'b1); if (w) err = 1; end
      16: begin rd = pend_word(1'b0); if (w) err = 1; end
      default: rd = 0;
    endcase
  endfunction

  // Reference model: one step per clock edge, on the values the DUT samples
  always @(posedge clk) begin : model
    bit evh[NC], evr[NC], swh[NC], swr[NC], clrv[NC];
    bit th, tr, err;
    int rd;
    if (cpurst) begin
      m_en = 0; m_hgrp = 0; m_rgrp = 0;
      for (int k = 0; k < NC; k++) begin
        m_hp[k] = 0; m_rp[k] = 0;
        m_h1e[k] = 0; m_h2e[k] = 0; m_h1x[k] = 0; m_h2x[k] = 0;
      end
      apb_q.delete();
      commit_cyc = -1;
    end else begin
      if (acc_pending) begin
        decode(acc_addr, acc_w, err, rd);
        apb_q.push_back('{rd, err, !acc_w, cyc + 2});
        commit_cyc = cyc + 2;
        c_addr = acc_addr; c_data = acc_data; c_w = acc_w; c_err = err;
      end
      for (int k = 0; k < NC; k++) begin
        evh[k] = m_h1e[k] && !m_h2e[k];
        evr[k] = m_h1x[k] && !m_h2x[k];
        swh[k] = 0; swr[k] = 0; clrv[k] = 0;
        if (commit_cyc == cyc && c_w && !c_err) begin
          if (c_addr == 'h14) swh[k] = c_data[k];
          if (c_addr == 'h18) swr[k] = c_data[k];
          if (c_addr == 'h1C) clrv[k] = c_data[k];
        end
      end
      for (int k = 0; k < NC; k++) begin
        th = swh[k];
        tr = swr[k];
        for (int s = 0; s < NC; s++) begin
          if (s != k && m_en[0] && m_hgrp[s] && m_hgrp[k] && evh[s] && !ack[k]) th = 1;
          if (s != k && m_en[0] && m_rgrp[s] && m_rgrp[k] && evr[s] && ack[k]) tr = 1;
        end
        if (clrv[k]) begin
          m_hp[k] = 0; m_rp[k] = 0;
        end else if (ack[k]) begin
          m_hp[k] = 0;
          if (tr) m_rp[k] = 1;
        end else begin
          m_rp[k] = 0;
          if (th) m_hp[k] = 1;
        end
      end
      if (commit_cyc == cyc && c_w && !c_err) begin
        if (c_addr == 0) m_en   = c_data & 1;
        if (c_addr == 4) m_hgrp = c_data & MASK;
        if (c_addr == 8) m_rgrp = c_data & MASK;
      end
      for (int k = 0; k < NC; k++) begin
        m_h2e[k] = m_h1e[k]; m_h1e[k] = enter_o[k];
        m_h2x[k] = m_h1x[k]; m_h1x[k] = exit_o[k];
      end
    end
    out_q.push_back('{pend_word(1'b1), pend_word(1'b0)});
    cyc++;
  end

  always @(negedge clk) begin : monitor
    out_exp_t o;
    apb_exp_t e;
    if (out_q.size() > 0) begin
      o = out_q.pop_front();
      check("enter_req", int'(enter_i), o.en);
      check("exit_req", int'(exit_i), o.ex);
    end
    if (pready_had) begin
      if (apb_q.size() == 0) begin
        check("apb_unexpected_pready", 1, 0);
      end else begin
        e = apb_q.pop_front();
        check("apb_pready_cycle", cyc, e.cyc);
        check("apb_perr", int'(perr_had), int'(e.err));
        if (e.is_rd && !e.err) check("apb_rdata", int'(prdata_had), e.rd);
      end
    end
  end

  task automatic apb_xfer(input bit w, input int a, input int d);
    @(negedge clk);
    psel_had = 1; penable_had = 1; pwrite_had = w; paddr_had = 8'(a); pwdata_had = d;
    acc_pending = 1; acc_addr = a; acc_data = d; acc_w = w;
    @(negedge clk);
    acc_pending = 0;
    check("apb_wait_pready", int'(pready_had), 0);
    @(negedge clk);
    psel_had = 0; penable_had = 0;
  endtask

  task automatic apb_wr(input int a, input int d); apb_xfer(1'b1, a, d); endtask
  task automatic apb_rd(input int a);              apb_xfer(1'b0, a, 0); endtask

  int addrs[11] = '{0, 4, 8, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20, 'h02, 'h3C};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_enter", int'(enter_i), 0);
    check("rst_exit", int'(exit_i), 0);
    check("rst_pready", int'(pready_had), 0);
    check("rst_perr", int'(perr_had), 0);
    check("rst_prdata", int'(prdata_had), 0);
    cpurst = 0;

    // halt broadcast in group 0b0111 and ack clearing
    apb_wr(4, 'h7);
    apb_wr(0, 1);
    @(negedge clk); enter_o[1] = 1;
    @(negedge clk); @(negedge clk);
    check("halt_bcast", int'(enter_i), 'b0101);
    ack[0] = 1; enter_o[1] = 0;
    @(negedge clk);
    check("halt_ack0", int'(enter_i), 'b0100);
    ack = 4'hF;
    @(negedge clk);
    check("halt_all_acked", int'(enter_i), 0);

    // resume broadcast, acks dropping one by one
    apb_wr(8, 'hF);
    exit_o[3] = 1;
    @(negedge clk); @(negedge clk);
    check("resume_bcast", int'(exit_i), 'b0111);
    exit_o[3] = 0;
    for (int i = 0; i < 3; i++) begin
      ack[i] = 0;
      @(negedge clk);
      check("resume_drop", int'(exit_i), 'b0111 & ('hF << (i + 1)));
    end

    // cross-trigger disabled; software halt still works
    apb_wr(0, 0);
    ack = 0;
    enter_o[0] = 1;
    repeat (3) @(negedge clk);
    check("xtrig_off", int'(enter_i), 0);
    enter_o[0] = 0;
    apb_wr('h14, 8);
    @(negedge clk);
    check("sw_halt", int'(enter_i), 'b1000);

    // halt trigger and SW_RESUME commit hit core2 in the same cycle
    apb_wr('h1C, 'hF);
    apb_wr(4, 'h5);
    apb_wr(0, 1);
    fork
      apb_wr('h18, 'h4);
      begin @(negedge clk); @(negedge clk); enter_o[0] = 1; end
    join
    @(negedge clk);
    check("conflict_enter", int'(enter_i), 'b0100);
    check("conflict_exit", int'(exit_i), 0);
    apb_rd('h0C);
    apb_rd('h10);
    enter_o[0] = 0;

    // error responses and masking
    apb_rd('h20);
    apb_wr('h0C, 'hF);
    apb_rd('h0C);
    apb_rd('h05);
    apb_wr(4, 'hFFFF_FFF5);
    apb_rd(4);

    // reset during the WAIT state
    @(negedge clk);
    psel_had = 1; penable_had = 1; pwrite_had = 1; paddr_had = 8'h04; pwdata_had = 'hA;
    acc_pending = 1; acc_addr = 4; acc_data = 'hA; acc_w = 1;
    @(negedge clk);
    acc_pending = 0;
    check("midrst_wait_pready", int'(pready_had), 0);
    cpurst = 1; psel_had = 0; penable_had = 0;
    @(negedge clk);
    cpurst = 0;
    check("midrst_pready", int'(pready_had), 0);
    check("midrst_enter", int'(enter_i), 0);
    check("midrst_exit", int'(exit_i), 0);
    apb_rd(4);

    // randomized traffic
    apb_wr(0, 1);
    apb_wr(4, 'hF);
    apb_wr(8, 'hF);
    fork
      begin
        repeat (1500) begin
          @(negedge clk);
          enter_o = 4'($urandom) & 4'($urandom);
          exit_o  = 4'($urandom) & 4'($urandom);
          for (int k = 0; k < NC; k++)
            if ($urandom_range(0, 4) == 0) ack[k] = ~ack[k];
        end
      end
      begin
        repeat (150) begin
          int a, d;
          a = addrs[$urandom_range(0, 10)];
          d = (a == 0) ? int'($urandom_range(0, 3) != 0) : int'($urandom);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if ($urandom_range(0, 9) < 6) apb_wr(a, d);
          else apb_rd(a);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("apb_queue_empty", apb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
